// File: rtl/timer_pkg.sv
// timer_pkg: clock-select and waveform encodings, flag bit positions and prescaler tap helpers for the timer unit.
package timer_pkg;
  typedef enum logic [2:0] {
    CS_STOP     = 3'd0,
    CS_CLK1     = 3'd1,
    CS_DIV8     = 3'd2,
    CS_DIV64    = 3'd3,
    CS_DIV256   = 3'd4,
    CS_DIV1024  = 3'd5,
    CS_EXT_FALL = 3'd6,
    CS_EXT_RISE = 3'd7
  } cs_e;
  typedef enum logic {
    WGM_NORMAL = 1'b0,
    WGM_CTC    = 1'b1
  } wgm_e;
  localparam int TOV_BIT = 0;
  localparam int PS_W = 10;
  localparam int unsigned PS_TAP8 = 3;
  localparam int unsigned PS_TAP64 = 6;
  localparam int unsigned PS_TAP256 = 8;
  localparam int unsigned PS_TAP1024 = 10;
  function automatic int OCF_BIT(input int i);
    return i + 1;
  endfunction
  // true on the cycle the low `bits` bits of the prescaler are about to roll over
  function automatic logic tap_done(input logic [PS_W-1:0] p, input int unsigned bits);
    logic [PS_W-1:0] m;
    m = PS_W'((1 << bits) - 1);
    return (p & m) == m;
  endfunction
endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler: free-running prescaler, t_pin synchroniser and edge detect, clock-select mux producing the count tick.
module timer_prescaler
  import timer_pkg::*;
(
  input  logic       sysClock,
  input  logic       system_reset,
  input  logic       t_pin_i,
  input  logic [2:0] cs_i,
  output logic       tick_o
);
  logic [PS_W-1:0] presc_q, presc_d;
  logic [2:0] pin_q, pin_d;
  logic rise, fall;
  assign presc_d = presc_q + 1'b1;
  assign pin_d = {pin_q[1:0], t_pin_i};
  // pin_q[1] is the synchronised level, pin_q[2] its value one cycle earlier
  assign rise = pin_q[1] & ~pin_q[2];
  assign fall = ~pin_q[1] & pin_q[2];
  always_comb begin
    tick_o = 1'b0;
    case (cs_i)
      CS_CLK1:     tick_o = 1'b1;
      CS_DIV8:     tick_o = tap_done(presc_q, PS_TAP8);
      CS_DIV64:    tick_o = tap_done(presc_q, PS_TAP64);
      CS_DIV256:   tick_o = tap_done(presc_q, PS_TAP256);
      CS_DIV1024:  tick_o = tap_done(presc_q, PS_TAP1024);
      CS_EXT_FALL: tick_o = fall;
      CS_EXT_RISE: tick_o = rise;
      default:     tick_o = 1'b0;
    endcase
  end
  always_ff @(posedge sysClock)
    if (!system_reset) begin
      presc_q <= '0;
      pin_q <= '0;
    end else begin
      presc_q <= presc_d;
      pin_q <= pin_d;
    end
endmodule

// File: rtl/timer_counter_unit.sv
// timer_counter_unit: WIDTH-bit timer/counter, NUM_CMP compare channels, normal/CTC modes, W1C flags, registered irq.
// Defining TIMER_OC_PIN_EN adds the oc_out pins that toggle on each compare match.
module timer_counter_unit
  import timer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NUM_CMP = 1
) (
  input  logic                     sysClock,
  input  logic                     system_reset,
  input  logic                     t_pin,
  input  logic [WIDTH-1:0]         tcnt_wdata,
  input  logic                     tcnt_we,
  input  logic [7:0]               tccr_wdata,
  input  logic                     tccr_we,
  input  logic [WIDTH-1:0]         ocr_wdata,
  input  logic [NUM_CMP-1:0]       ocr_we,
  input  logic [NUM_CMP:0]         timsk_wdata,
  input  logic                     timsk_we,
  input  logic [NUM_CMP:0]         tifr_wdata,
  input  logic                     tifr_we,
  output logic [WIDTH-1:0]         tcnt,
  output logic [7:0]               tccr,
  output logic [NUM_CMP*WIDTH-1:0] ocr,
  output logic [NUM_CMP:0]         timsk,
  output logic [NUM_CMP:0]         tifr,
  output logic                     irq
`ifdef TIMER_OC_PIN_EN
  ,
  output logic [NUM_CMP-1:0]       oc_out
`endif
);
  localparam int FW = NUM_CMP + 1;
  logic [WIDTH-1:0] tcnt_q, tcnt_d;
  logic [7:0] tccr_q, tccr_d;
  logic [NUM_CMP-1:0][WIDTH-1:0] ocr_q, ocr_d;
  logic [FW-1:0] timsk_q, timsk_d, tifr_q, tifr_d, set_f;
  logic irq_q, irq_d;
  logic tick, cnt_en, ctc_clr;
  logic [NUM_CMP-1:0] match;
  timer_prescaler u_presc (
    .sysClock,
    .system_reset,
    .t_pin_i(t_pin),
    .cs_i(tccr_q[2:0]),
    .tick_o(tick)
  );
  // a counter write swallows the tick of the same cycle, including its compare
  assign cnt_en = tick && !tcnt_we;
  assign ctc_clr = tccr_q[3] == WGM_CTC && tcnt_q == ocr_q[0];
  always_comb begin
    ocr_d = ocr_q;
    match = '0;
    set_f = '0;
    for (int i = 0; i < NUM_CMP; i++) begin
      ocr_d[i] = ocr_we[i] ? ocr_wdata : ocr_q[i];
      match[i] = cnt_en && tcnt_q == ocr_q[i];
      set_f[OCF_BIT(i)] = match[i];
    end
    set_f[TOV_BIT] = cnt_en && !ctc_clr && &tcnt_q;
  end
  assign tcnt_d = tcnt_we ? tcnt_wdata : !tick ? tcnt_q : ctc_clr ? '0 : tcnt_q + 1'b1;
  assign tccr_d = tccr_we ? tccr_wdata : tccr_q;
  assign timsk_d = timsk_we ? timsk_wdata : timsk_q;
  // set is OR-ed after the clear so hardware wins a same-cycle W1C
  assign tifr_d = (tifr_q & ~(tifr_we ? tifr_wdata : '0)) | set_f;
  assign irq_d = |(tifr_q & timsk_q);
  always_ff @(posedge sysClock)
    if (!system_reset) begin
      tcnt_q <= '0;
      tccr_q <= '0;
      ocr_q <= '0;
      timsk_q <= '0;
      tifr_q <= '0;
      irq_q <= 1'b0;
    end else begin
      tcnt_q <= tcnt_d;
      tccr_q <= tccr_d;
      ocr_q <= ocr_d;
      timsk_q <= timsk_d;
      tifr_q <= tifr_d;
      irq_q <= irq_d;
    end
  assign tcnt = tcnt_q;
  assign tccr = tccr_q;
  assign ocr = ocr_q;
  assign timsk = timsk_q;
  assign tifr = tifr_q;
  assign irq = irq_q;
`ifdef TIMER_OC_PIN_EN
  logic [NUM_CMP-1:0] oc_q;
  always_ff @(posedge sysClock)
    if (!system_reset) oc_q <= '0;
    else oc_q <= oc_q ^ match;
  assign oc_out = oc_q;
`endif
endmodule
